// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped instruction cache with a single-beat L2 line refill.
// A miss latches the PC, requests the line over the address handshake and then waits for the data handshake.
module instruction_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int L2_BUS_WIDTH  = 512,
    parameter int CACHE_LINES   = 64
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       STALL_INSTRUCTION_CACHE,
    input  logic [ADDRESS_WIDTH-1:0]   PC,
    input  logic                       PC_VALID,
    output logic [ADDRESS_WIDTH-1:0]   INSTRUCTION,
    output logic                       INSTRUCTION_CACHE_READY,
    input  logic                       ADDRESS_TO_L2_READY_INS,
    output logic                       ADDRESS_TO_L2_VALID_INS,
    output logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2_INS,
    output logic                       DATA_FROM_L2_READY_INS,
    input  logic                       DATA_FROM_L2_VALID_INS,
    input  logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2_INS
);
    localparam int OFF_W = $clog2(L2_BUS_WIDTH / ADDRESS_WIDTH);
    localparam int IDX_W = $clog2(CACHE_LINES);
    localparam int TAG_W = ADDRESS_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [ADDRESS_WIDTH-1:0] NOP = ADDRESS_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                    r_state, w_next;
    logic [ADDRESS_WIDTH-3:0]  r_pc;
    logic [CACHE_LINES-1:0]    r_valid;
    logic [TAG_W-1:0]          r_tag [CACHE_LINES];
    logic [L2_BUS_WIDTH-1:0]   r_data [CACHE_LINES];
    logic [ADDRESS_WIDTH-1:0]  r_instr;
    logic                      r_ready;

    logic [OFF_W-1:0] w_off, w_miss_off;
    logic [IDX_W-1:0] w_idx, w_miss_idx;
    logic [TAG_W-1:0] w_tag, w_miss_tag;
    logic             w_hit, w_lookup, w_fill;

    assign w_off      = PC[OFF_W+1:2];
    assign w_idx      = PC[OFF_W+IDX_W+1:OFF_W+2];
    assign w_tag      = PC[ADDRESS_WIDTH-1:OFF_W+IDX_W+2];
    assign w_miss_off = r_pc[OFF_W-1:0];
    assign w_miss_idx = r_pc[OFF_W+IDX_W-1:OFF_W];
    assign w_miss_tag = r_pc[ADDRESS_WIDTH-3:OFF_W+IDX_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_lookup   = (r_state == S_IDLE) && !STALL_INSTRUCTION_CACHE && PC_VALID;
    assign w_fill     = (r_state == S_WAIT) && DATA_FROM_L2_VALID_INS;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (w_lookup && !w_hit) ? S_REQ : S_IDLE;
            S_REQ:   w_next = ADDRESS_TO_L2_READY_INS ? S_WAIT : S_REQ;
            S_WAIT:  w_next = DATA_FROM_L2_VALID_INS ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ADDRESS_TO_L2_VALID_INS = (r_state == S_REQ);
        DATA_FROM_L2_READY_INS  = (r_state == S_WAIT);
        ADDRESS_TO_L2_INS       = {r_pc[ADDRESS_WIDTH-3:OFF_W], {OFF_W{1'b0}}};
        INSTRUCTION             = r_instr;
        INSTRUCTION_CACHE_READY = r_ready;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= '0;
            r_instr <= NOP;
            r_ready <= 1'b1;
            r_pc    <= '0;
        end else begin
            if (w_lookup && w_hit) begin
                r_instr <= r_data[w_idx][w_off*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end else if (w_lookup) begin
                r_pc    <= PC[ADDRESS_WIDTH-1:2];
                r_ready <= 1'b0;
            end else if (r_state == S_IDLE && !STALL_INSTRUCTION_CACHE) begin
                r_instr <= NOP;
            end
            if (w_fill) begin
                r_valid[w_miss_idx] <= 1'b1;
                r_instr             <= DATA_FROM_L2_INS[w_miss_off*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                r_ready             <= 1'b1;
            end
        end
    end

    // Arrays are only trusted through r_valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_data[w_miss_idx] <= DATA_FROM_L2_INS;
            r_tag[w_miss_idx]  <= w_miss_tag;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: table-driven and randomized checks of instruction_cache against a line/tag model.
module tb_instruction_cache;
    logic         CLK = 0, RST_N = 1, STALL = 0, PC_VALID = 0, AREADY = 0, DVALID = 0;
    logic [31:0]  PC = 0;
    logic [511:0] DATA = 0;
    logic [31:0]  INSTR;
    logic         READY, AVALID, DREADY;
    logic [29:0]  ADDR;

    int unsigned  n_pass = 0, n_total = 0;
    bit           mvalid [64];
    int unsigned  mtag [64];
    logic [31:0]  exp_instr = 32'h13;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        stall;
        logic [31:0] instr;
    } vec_t;
    vec_t vecs [7];

    instruction_cache dut (
        .CLK(CLK), .RST_N(RST_N), .STALL_INSTRUCTION_CACHE(STALL), .PC(PC), .PC_VALID(PC_VALID),
        .INSTRUCTION(INSTR), .INSTRUCTION_CACHE_READY(READY),
        .ADDRESS_TO_L2_READY_INS(AREADY), .ADDRESS_TO_L2_VALID_INS(AVALID), .ADDRESS_TO_L2_INS(ADDR),
        .DATA_FROM_L2_READY_INS(DREADY), .DATA_FROM_L2_VALID_INS(DVALID), .DATA_FROM_L2_INS(DATA)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [31:0] word(int unsigned l, int unsigned i);
        return (l == 1 && i == 0) ? 32'hAAAA_0000 : l * 32'h9E37_79B9 + i * 32'h0100_0193;
    endfunction

    function automatic logic [511:0] line(int unsigned l);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = word(l, i);
        return r;
    endfunction

    function automatic bit is_hit(int unsigned pc);
        return mvalid[(pc >> 6) % 64] && mtag[(pc >> 6) % 64] == (pc >> 12);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_instr", INSTR, 32'h13);
        chk("rst_ready", READY, 1);
        chk("rst_avalid", AVALID, 0);
        chk("rst_dready", DREADY, 0);
        chk("rst_addr", ADDR, 0);
    endtask

    task automatic idle_op(logic [31:0] pc, logic v, logic s);
        PC = pc; PC_VALID = v; STALL = s;
        step();
        if (!s) exp_instr = v ? word(pc >> 6, (pc >> 2) % 16) : 32'h13;
        chk("idle_instr", INSTR, exp_instr);
        chk("idle_ready", READY, 1);
        chk("idle_avalid", AVALID, 0);
    endtask

    task automatic miss_fill(logic [31:0] pc, int na, int nd);
        logic [29:0] a;
        a = 30'((pc >> 6) << 4);
        PC = pc; PC_VALID = 1; STALL = 0; AREADY = 0; DVALID = 0;
        step();
        chk("miss_ready", READY, 0);
        chk("miss_avalid", AVALID, 1);
        chk("miss_addr", ADDR, a);
        chk("miss_instr_hold", INSTR, exp_instr);
        for (int k = 0; k < na; k++) begin
            PC = $urandom; PC_VALID = 1'($urandom); STALL = 1'($urandom);
            DVALID = 1'($urandom); DATA = {16{$urandom}};
            step();
            chk("req_avalid", AVALID, 1);
            chk("req_addr", ADDR, a);
            chk("req_ready", READY, 0);
        end
        AREADY = 1;
        step();
        AREADY = 0; DVALID = 0;
        chk("wait_dready", DREADY, 1);
        chk("wait_avalid", AVALID, 0);
        chk("wait_ready", READY, 0);
        for (int k = 0; k < nd; k++) begin
            AREADY = 1'($urandom); STALL = 1'($urandom); PC = $urandom;
            step();
            chk("wait_dready_hold", DREADY, 1);
            chk("wait_ready_low", READY, 0);
        end
        AREADY = 0; DVALID = 1; DATA = line(pc >> 6);
        step();
        DVALID = 0; PC_VALID = 0; STALL = 0;
        mvalid[(pc >> 6) % 64] = 1;
        mtag[(pc >> 6) % 64] = pc >> 12;
        exp_instr = word(pc >> 6, (pc >> 2) % 16);
        chk("fill_instr", INSTR, exp_instr);
        chk("fill_ready", READY, 1);
        chk("fill_dready", DREADY, 0);
    endtask

    initial begin
        vecs[0] = '{32'h44, 1'b1, 1'b0, word(1, 1)};
        vecs[1] = '{32'h48, 1'b1, 1'b1, word(1, 1)};
        vecs[2] = '{32'h7C, 1'b1, 1'b0, word(1, 15)};
        vecs[3] = '{32'h00, 1'b0, 1'b0, 32'h13};
        vecs[4] = '{32'h40, 1'b1, 1'b1, 32'h13};
        vecs[5] = '{32'h4F, 1'b1, 1'b0, word(1, 3)};
        vecs[6] = '{32'h60, 1'b1, 1'b0, word(1, 8)};

        #2 RST_N = 0;
        #2 chk_reset_outputs();
        step();
        step();
        RST_N = 1;

        PC = 32'h40; PC_VALID = 1;
        step();
        chk("first_ready", READY, 0);
        chk("first_avalid", AVALID, 1);
        chk("first_addr", ADDR, 30'h10);
        chk("first_dready", DREADY, 0);
        PC_VALID = 0; AREADY = 1;
        step();
        chk("first_wait_dready", DREADY, 1);
        chk("first_wait_ready", READY, 0);
        AREADY = 0; DVALID = 1; DATA = line(1);
        step();
        DVALID = 0;
        chk("first_fill_instr", INSTR, 32'hAAAA_0000);
        chk("first_fill_ready", READY, 1);
        mvalid[1] = 1; mtag[1] = 0; exp_instr = 32'hAAAA_0000;

        for (int k = 0; k < 7; k++) begin
            PC = vecs[k].pc; PC_VALID = vecs[k].valid; STALL = vecs[k].stall;
            step();
            chk($sformatf("vec%0d_instr", k), INSTR, vecs[k].instr);
            chk($sformatf("vec%0d_ready", k), READY, 1);
            chk($sformatf("vec%0d_avalid", k), AVALID, 0);
            exp_instr = vecs[k].instr;
        end

        miss_fill(32'h1040, 0, 0);
        chk("tag_conflict_miss", is_hit(32'h40), 0);
        miss_fill(32'h40, 5, 2);
        idle_op(32'h1044, 1, 1);
        idle_op(32'h0, 1, 1);

        PC = 32'h2040; PC_VALID = 1; STALL = 0;
        step();
        chk("rw_miss_avalid", AVALID, 1);
        PC_VALID = 0; AREADY = 1;
        step();
        AREADY = 0;
        chk("rw_in_wait", DREADY, 1);
        #2 RST_N = 0;
        #1 chk_reset_outputs();
        DVALID = 1; DATA = line(32'h2040 >> 6);
        step();
        chk_reset_outputs();
        RST_N = 1;
        for (int i = 0; i < 64; i++) mvalid[i] = 0;
        exp_instr = 32'h13;
        step();
        chk("late_beat_instr", INSTR, 32'h13);
        chk("late_beat_ready", READY, 1);
        chk("late_beat_dready", DREADY, 0);
        DVALID = 0;
        miss_fill(32'h2040, 1, 0);
        miss_fill(32'h40, 0, 1);

        for (int it = 0; it < 300; it++) begin
            logic [31:0] pc;
            int          op;
            pc = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 63);
            op = $urandom_range(0, 9);
            if (op < 6) begin
                if (is_hit(pc)) idle_op(pc, 1, 0);
                else miss_fill(pc, $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (op < 8) begin
                idle_op(pc, 0, 0);
            end else begin
                idle_op(pc, 1'($urandom), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
